vx_index_pool: RTL and testbench
================================

// Module: vx_index_pool
// PURPOSE
//  Multi-port slot allocator with a data table. Hands out the lowest free index, stores a payload
//  per slot, and frees slots from up to NUM_REL independent release ports in one cycle.
//  Sits between issue logic and out-of-order completion paths (e.g. LSU/MSHR tags).
//  Provides occupancy count and almost-full for back-pressure.
//  Next-generation index buffer: multiple release and read ports, occupancy tracking, async active-low reset.
// PARAMETERS
//  DATAW      32          payload width per slot
//  SIZE       16          number of slots (>=2)
//  NUM_REL    2           release ports (>=1)
//  NUM_RD     2           read ports (>=1)
//  AF_THRESH  SIZE-2      almost_full asserted when count >= AF_THRESH
//  LUTRAM     1           1: combinational read; 0: registered read, 1-cycle latency
//  ADDRW      LOG2UP(SIZE) slot index width (derived)
//  CNTW       LOG2UP(SIZE+1) occupancy counter width (derived)
// PORTS
//  clk           in   1               clock; single clock domain
//  reset_n       in   1               asynchronous, active-low reset
//  acquire_slot  in   1               allocate write_addr, store write_data
//  write_addr    out  ADDRW           index granted by the next acquire
//  write_data    in   DATAW           payload written on acquire
//  read_addr     in   NUM_RD*ADDRW    per-port read index
//  read_data     out  NUM_RD*DATAW    per-port payload
//  release_slot  in   NUM_REL         per-port release strobe
//  release_addr  in   NUM_REL*ADDRW   per-port index to free
//  count         out  CNTW            slots in use
//  empty         out  1               count == 0
//  full          out  1               count == SIZE
//  almost_full   out  1               count >= AF_THRESH
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the surrounding reset network): free mask all-ones,
//    write_addr=0, count=0, empty=1, full=0, almost_full=(AF_THRESH==0). Data table not reset.
//  - State: free mask (SIZE bits), write_addr_r, count_r, flag registers. All outputs registered
//    except read_data when LUTRAM=1.
//  - Next mask each cycle: start from the current mask; OR in the release_addr bit for every
//    asserted release port; then clear the write_addr_r bit if acquire_slot.
//  - write_addr_r <= index of the lowest set bit of the next mask. A slot released in cycle t is
//    grantable from cycle t+1.
//  - count_r <= count_r + acquire - popcount(distinct valid releases). Width CNTW. No wrap is
//    possible under legal stimulus.
//  - empty, full and almost_full are registered from the next-state count. full => no free bit,
//    and write_addr holds its last value.
//  - Acquire while full: illegal. Assertion fires; mask, count and RAM are unchanged (acquire masked).
//  - Release of a free slot: illegal. Assertion fires; the bit stays set and count is not decremented.
//  - Two release ports with the same address in one cycle: illegal. Assertion fires; the release
//    is counted once.
//  - Acquire plus releases in the same cycle: both apply. count changes by the net amount.
//    full can deassert in the same cycle an acquire would otherwise fill the pool.
//  - Data table: written at write_addr_r on acquire_slot. Written data is readable from the next
//    cycle. Same-cycle read of the slot being written returns old data.
//  - LUTRAM=1: read_data follows read_addr combinationally.
//    LUTRAM=0: read_data is registered one cycle after read_addr.
//  - Mid-operation reset: all allocations are discarded immediately. Stale payloads remain in RAM
//    and are not valid.
// TESTING
//  1. Reset -> count=0, empty=1, full=0, write_addr=0. Acquire 16x back-to-back (SIZE=16) ->
//     grants 0..15, full=1 after the 16th, almost_full=1 once count>=14.
//  2. Full pool: release ports 0/1 free slots 5 and 9 in one cycle -> next cycle count=14,
//     full=0, write_addr=5. Following acquire -> write_addr=9.
//  3. Same cycle: acquire slot 3 and release slot 7 (count=8) -> count stays 8, slot 3 used,
//     slot 7 free.
//  4. Acquire slot 2 with write_data=0xDEADBEEF. Read 2 on both ports next cycle -> 0xDEADBEEF
//     (LUTRAM=1 same cycle; LUTRAM=0 one cycle later).
//  5. Illegal cases: double release of slot 4 on both ports, and acquire while full -> assertions
//     fire, count correct, mask unchanged.
//  6. Assert reset_n low mid-stream with count=11 -> outputs return to reset values asynchronously.
//     After release of reset, first grant is 0.

Source files
------------

// File: rtl/vx_index_pool.sv
// Multi-port slot allocator: grants the lowest free index, stores a payload per slot and frees
// slots from several release ports per cycle, with occupancy count and full/almost-full flags.
module vx_index_pool #(
  parameter int unsigned DATAW     = 32,
  parameter int unsigned SIZE      = 16,
  parameter int unsigned NUM_REL   = 2,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned AF_THRESH = SIZE - 2,
  parameter bit          LUTRAM    = 1'b1,
  parameter bit          ASSERT_EN = 1'b1,
  localparam int unsigned ADDRW    = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned CNTW     = $clog2(SIZE + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_acquire_slot,
  output logic [ADDRW-1:0]          o_write_addr,
  input  logic [DATAW-1:0]          i_write_data,
  input  logic [NUM_RD*ADDRW-1:0]   i_read_addr,
  output logic [NUM_RD*DATAW-1:0]   o_read_data,
  input  logic [NUM_REL-1:0]        i_release_slot,
  input  logic [NUM_REL*ADDRW-1:0]  i_release_addr,
  output logic [CNTW-1:0]           o_count,
  output logic                      o_empty,
  output logic                      o_full,
  output logic                      o_almost_full
);

  logic [SIZE-1:0]  r_free;
  logic [ADDRW-1:0] r_waddr;
  logic [CNTW-1:0]  r_count;
  logic             r_empty, r_full, r_afull;
  logic [DATAW-1:0] r_mem [SIZE];

  logic [SIZE-1:0]  w_rel_req, w_rel_valid, w_free_d;
  logic [CNTW-1:0]  w_rel_cnt, w_count_d;
  logic [ADDRW-1:0] w_waddr_d;
  logic             w_acq;

  always_comb begin
    w_rel_req = '0;
    for (int s = 0; s < SIZE; s++) begin
      for (int p = 0; p < NUM_REL; p++) begin
        if (i_release_slot[p] && (i_release_addr[p*ADDRW +: ADDRW] == ADDRW'(s))) begin
          w_rel_req[s] = 1'b1;
        end
      end
    end
    // Releases of already-free slots and duplicate ports collapse to one valid bit per slot.
    w_rel_valid = w_rel_req & ~r_free;
    w_acq       = i_acquire_slot & ~r_full;
    w_free_d    = r_free | w_rel_valid;
    if (w_acq) w_free_d[r_waddr] = 1'b0;

    w_rel_cnt = '0;
    for (int s = 0; s < SIZE; s++) begin
      w_rel_cnt = w_rel_cnt + CNTW'(w_rel_valid[s]);
    end
    w_count_d = r_count + CNTW'(w_acq) - w_rel_cnt;

    w_waddr_d = r_waddr;
    for (int s = SIZE - 1; s >= 0; s--) begin
      if (w_free_d[s]) w_waddr_d = ADDRW'(s);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_free  <= '1;
      r_waddr <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= (AF_THRESH == 0);
    end else begin
      r_free  <= w_free_d;
      r_waddr <= w_waddr_d;
      r_count <= w_count_d;
      r_empty <= (w_count_d == '0);
      r_full  <= (w_count_d == CNTW'(SIZE));
      r_afull <= (w_count_d >= CNTW'(AF_THRESH));
    end
  end

  // Payload table is intentionally not reset; stale entries are simply unallocated.
  always_ff @(posedge i_clk) begin
    if (w_acq) r_mem[r_waddr] <= i_write_data;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDRW-1:0] w_raddr;
    assign w_raddr = i_read_addr[g*ADDRW +: ADDRW];
    if (LUTRAM) begin : g_comb
      assign o_read_data[g*DATAW +: DATAW] = r_mem[w_raddr];
    end else begin : g_reg
      logic [DATAW-1:0] r_rdata;
      always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[w_raddr];
      end
      assign o_read_data[g*DATAW +: DATAW] = r_rdata;
    end
  end

  assign o_write_addr  = r_waddr;
  assign o_count       = r_count;
  assign o_empty       = r_empty;
  assign o_full        = r_full;
  assign o_almost_full = r_afull;

  if (ASSERT_EN) begin : g_assert
    a_acq_full: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_acquire_slot && r_full));
    for (genvar p = 0; p < NUM_REL; p++) begin : g_rel
      a_rel_free: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(i_release_slot[p] && r_free[i_release_addr[p*ADDRW +: ADDRW]]));
      for (genvar q = p + 1; q < NUM_REL; q++) begin : g_dup
        a_rel_dup: assert property (@(posedge i_clk) disable iff (!i_reset_n)
          !(i_release_slot[p] && i_release_slot[q] &&
            (i_release_addr[p*ADDRW +: ADDRW] == i_release_addr[q*ADDRW +: ADDRW])));
      end
    end
  end

endmodule

// File: tb/tb_vx_index_pool.sv
// Bench for vx_index_pool: combinational-read and registered-read instances share stimulus and
// are checked every cycle against a slot-array model, plus literal expectations per scenario.
module tb_vx_index_pool;
  localparam int SIZE = 16;

  logic        clk = 1'b0;
  logic        rst_n, acq;
  logic [31:0] wdata;
  logic [7:0]  raddr;
  logic [1:0]  rel;
  logic [7:0]  reladdr;

  logic [3:0]  waddr0, waddr1;
  logic [63:0] rdata0, rdata1;
  logic [4:0]  cnt0, cnt1;
  logic        empty0, empty1, full0, full1, af0, af1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: which slots are allocated, their payloads, and the current grant index.
  bit          m_used [SIZE];
  bit          m_wr   [SIZE];
  logic [31:0] m_mem  [SIZE];
  int          m_waddr;
  logic [31:0] m_rd_q [2];
  bit          m_rd_q_vld [2];

  always #5 clk = ~clk;

  vx_index_pool #(.LUTRAM(1'b1), .ASSERT_EN(1'b0)) u_dut_lut (
    .i_clk(clk), .i_reset_n(rst_n), .i_acquire_slot(acq), .o_write_addr(waddr0),
    .i_write_data(wdata), .i_read_addr(raddr), .o_read_data(rdata0),
    .i_release_slot(rel), .i_release_addr(reladdr), .o_count(cnt0), .o_empty(empty0),
    .o_full(full0), .o_almost_full(af0)
  );

  vx_index_pool #(.LUTRAM(1'b0), .ASSERT_EN(1'b0)) u_dut_reg (
    .i_clk(clk), .i_reset_n(rst_n), .i_acquire_slot(acq), .o_write_addr(waddr1),
    .i_write_data(wdata), .i_read_addr(raddr), .o_read_data(rdata1),
    .i_release_slot(rel), .i_release_addr(reladdr), .o_count(cnt1), .o_empty(empty1),
    .o_full(full1), .o_almost_full(af1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int s = 0; s < SIZE; s++) c += int'(m_used[s]);
    return c;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SIZE; s++) begin
      m_used[s] = 1'b0;
      m_wr[s]   = 1'b0;
    end
    m_waddr = 0;
    m_rd_q_vld[0] = 1'b0;
    m_rd_q_vld[1] = 1'b0;
  endtask

  task automatic model_update();
    bit freeing [SIZE];
    for (int p = 0; p < 2; p++) begin
      m_rd_q[p]     = m_mem[raddr[p*4 +: 4]];
      m_rd_q_vld[p] = m_wr[raddr[p*4 +: 4]];
    end
    for (int s = 0; s < SIZE; s++) freeing[s] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (rel[p] && m_used[reladdr[p*4 +: 4]]) freeing[reladdr[p*4 +: 4]] = 1'b1;
    end
    if (acq && m_count() < SIZE) begin
      m_mem[m_waddr]  = wdata;
      m_wr[m_waddr]   = 1'b1;
      m_used[m_waddr] = 1'b1;
    end
    for (int s = 0; s < SIZE; s++) if (freeing[s]) m_used[s] = 1'b0;
    for (int s = SIZE - 1; s >= 0; s--) if (!m_used[s]) m_waddr = s;
  endtask

  task automatic step(input bit a, input logic [31:0] d, input logic [1:0] r,
                      input logic [3:0] ra0, input logic [3:0] ra1,
                      input logic [3:0] rd0, input logic [3:0] rd1);
    acq = a; wdata = d; rel = r; reladdr = {ra1, ra0}; raddr = {rd1, rd0};
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cmp_dut(input string tag, input logic [3:0] wa, input logic [4:0] c,
                         input logic e, input logic f, input logic a);
    int mc;
    mc = m_count();
    chk({tag, ".count"}, 32'(c), mc);
    chk({tag, ".empty"}, 32'(e), 32'(mc == 0));
    chk({tag, ".full"}, 32'(f), 32'(mc == SIZE));
    chk({tag, ".almost_full"}, 32'(a), 32'(mc >= SIZE - 2));
    chk({tag, ".write_addr"}, 32'(wa), m_waddr);
  endtask

  always @(negedge clk) begin : compare
    int ra;
    if (chk_en) begin
      cmp_dut("lut", waddr0, cnt0, empty0, full0, af0);
      cmp_dut("reg", waddr1, cnt1, empty1, full1, af1);
      for (int p = 0; p < 2; p++) begin
        ra = int'(raddr[p*4 +: 4]);
        if (m_wr[ra]) chk($sformatf("lut.rdata%0d", p), rdata0[p*32 +: 32], m_mem[ra]);
        if (m_rd_q_vld[p]) chk($sformatf("reg.rdata%0d", p), rdata1[p*32 +: 32], m_rd_q[p]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; acq = 1'b0; wdata = '0; rel = '0; reladdr = '0; raddr = '0;
    model_reset();
    #12;
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.empty", 32'(empty0), 1);
    chk("rst.full", 32'(full0), 0);
    chk("rst.write_addr", 32'(waddr0), 0);
    chk("rst.almost_full", 32'(af1), 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 2'b00, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Fill the pool back-to-back.
    for (int i = 0; i < SIZE; i++) begin
      chk("fill.grant", 32'(waddr0), i);
      step(1, 32'h1000 + i, 2'b00, 0, 0, 4'(i), 0);
      if (i == 12) chk("fill.af_at13", 32'(af0), 0);
      if (i == 13) chk("fill.af_at14", 32'(af0), 1);
    end
    chk("fill.count", 32'(cnt0), 16);
    chk("fill.full", 32'(full0), 1);
    chk("fill.hold_addr", 32'(waddr0), 15);

    // Dual release from full.
    step(0, 0, 2'b11, 5, 9, 0, 0);
    chk("rel2.count", 32'(cnt0), 14);
    chk("rel2.full", 32'(full0), 0);
    chk("rel2.write_addr", 32'(waddr0), 5);
    step(1, 32'h2005, 2'b00, 0, 0, 5, 9);
    chk("rel2.next_grant", 32'(waddr0), 9);
    step(1, 32'h2009, 2'b00, 0, 0, 5, 9);
    chk("rel2.refull", 32'(full1), 1);

    // Leave 8 in use with slot 3 lowest free, then acquire 3 and release 7 together.
    step(0, 0, 2'b11, 3, 8, 0, 0);
    step(0, 0, 2'b11, 10, 11, 0, 0);
    step(0, 0, 2'b11, 12, 13, 0, 0);
    step(0, 0, 2'b11, 14, 15, 0, 0);
    chk("mix.count_pre", 32'(cnt0), 8);
    chk("mix.addr_pre", 32'(waddr0), 3);
    step(1, 32'h3003, 2'b01, 7, 0, 3, 7);
    chk("mix.count", 32'(cnt0), 8);
    chk("mix.write_addr", 32'(waddr0), 7);

    // Payload round trip through slot 2; port 0 reads slot 2 while it is being overwritten.
    step(0, 0, 2'b01, 2, 0, 0, 0);
    chk("data.addr", 32'(waddr0), 2);
    step(1, 32'hDEADBEEF, 2'b00, 0, 0, 2, 2);
    acq = 1'b0; raddr = {4'd2, 4'd2};
    #1;
    chk("data.lut_rd", rdata0[31:0], 32'hDEADBEEF);
    chk("data.lut_rd1", rdata0[63:32], 32'hDEADBEEF);
    step(0, 0, 2'b00, 0, 0, 2, 2);
    chk("data.reg_rd", rdata1[31:0], 32'hDEADBEEF);
    chk("data.reg_rd1", rdata1[63:32], 32'hDEADBEEF);

    // Illegal: same slot on both ports, release of a free slot, acquire while full.
    step(0, 0, 2'b11, 4, 4, 0, 0);
    chk("ill.dup_count", 32'(cnt0), 7);
    step(0, 0, 2'b01, 4, 0, 0, 0);
    chk("ill.free_rel_count", 32'(cnt0), 7);
    chk("ill.free_rel_addr", 32'(waddr0), 4);
    for (int i = 0; i < 9; i++) step(1, 32'h5000 + i, 2'b00, 0, 0, 4'(i), 15);
    chk("ill.full", 32'(full0), 1);
    step(1, 32'hBAD0BAD0, 2'b00, 0, 0, 15, 4);
    chk("ill.acq_full_count", 32'(cnt0), 16);
    chk("ill.acq_full_addr", 32'(waddr0), 15);
    acq = 1'b0;
    #1;
    chk("ill.ram_kept", rdata0[31:0], 32'h5008);

    // Mid-stream async reset with 11 in use.
    step(0, 0, 2'b11, 0, 1, 0, 0);
    step(0, 0, 2'b11, 2, 3, 0, 0);
    step(0, 0, 2'b01, 6, 0, 0, 0);
    chk("areset.count_pre", 32'(cnt0), 11);
    chk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset.count", 32'(cnt0), 0);
    chk("areset.empty", 32'(empty0), 1);
    chk("areset.write_addr", 32'(waddr0), 0);
    chk("areset.reg_count", 32'(cnt1), 0);
    chk("areset.reg_af", 32'(af1), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 2'b00, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("post.grant0", 32'(waddr0), 0);
    step(1, 32'h6000, 2'b00, 0, 0, 0, 0);
    chk("post.grant1", 32'(waddr0), 1);
    chk("post.count", 32'(cnt0), 1);
    step(0, 0, 2'b00, 0, 0, 0, 0);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
